// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit for the E stage.
// Owns the HI/LO register pair. mult/multu/div/divu compute their full
// result on the accepting edge into pending registers, then hold Busy for
// a fixed number of cycles before committing to HI/LO. mthi/mtlo write
// directly while idle; mfhi/mflo are served combinationally on MDOut.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;
    logic [31:0]        p_hi_reg;
    logic [31:0]        p_lo_reg;
    logic               p_wr_reg;

    // Operation decode and full-width result computation
    logic        is_mul;
    logic        is_div;
    logic        mul_signed;
    logic        div_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic        div_zero;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] div_d_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] res_hi_next;
    logic [31:0] res_lo_next;
    logic        res_wr_next;

    // Combinational arithmetic: multiply via sign/zero extension to 64 bits,
    // divide via unsigned magnitudes with signs re-applied afterwards, which
    // also handles 0x80000000 / -1 without overflow trouble.
    always_comb begin
        is_mul      = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
        is_div      = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
        mul_signed  = (MDUOp == OP_MULT);
        div_signed  = (MDUOp == OP_DIV);

        mul_a       = {{32{mul_signed & A[31]}}, A};
        mul_b       = {{32{mul_signed & B[31]}}, B};
        prod        = mul_a * mul_b;

        div_zero    = (B == 32'd0);
        div_n       = (div_signed && A[31]) ? (32'd0 - A) : A;
        div_d       = (div_signed && B[31]) ? (32'd0 - B) : B;
        // Guard the divider input; the result is discarded on divide by zero.
        div_d_safe  = div_zero ? 32'd1 : div_d;
        uq          = div_n / div_d_safe;
        ur          = div_n % div_d_safe;
        neg_q       = div_signed & (A[31] ^ B[31]);
        neg_r       = div_signed & A[31];

        if (is_mul) begin
            res_hi_next = prod[63:32];
            res_lo_next = prod[31:0];
            res_wr_next = 1'b1;
        end else begin
            res_hi_next = neg_r ? (32'd0 - ur) : ur;
            res_lo_next = neg_q ? (32'd0 - uq) : uq;
            res_wr_next = ~div_zero;
        end
    end

    // IDLE/RUN control, HI/LO ownership and the latency counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            p_hi_reg  <= 32'd0;
            p_lo_reg  <= 32'd0;
            p_wr_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Start && (is_mul || is_div)) begin
                        p_hi_reg  <= res_hi_next;
                        p_lo_reg  <= res_lo_next;
                        p_wr_reg  <= res_wr_next;
                        cnt_reg   <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                    end else if (MDUOp == OP_MTHI) begin
                        hi_reg <= A;
                    end else if (MDUOp == OP_MTLO) begin
                        lo_reg <= A;
                    end
                end
                ST_RUN: begin
                    // All requests are ignored here; upstream holds MD-class ops.
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        if (p_wr_reg) begin
                            hi_reg <= p_hi_reg;
                            lo_reg <= p_lo_reg;
                        end
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Read port for mfhi/mflo straight from the architectural registers
    always_comb begin
        MDOut = 32'd0;
        case (MDUOp)
            OP_MFHI: MDOut = hi_reg;
            OP_MFLO: MDOut = lo_reg;
            default: MDOut = 32'd0;
        endcase
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops
// checked against a plain-arithmetic HI/LO model.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .MDUOp (MDUOp),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    // Called at a negedge: presents the request for exactly one rising edge.
    task automatic issue_op(input logic [3:0] op, input logic st,
                            input logic [31:0] a, input logic [31:0] b);
        MDUOp = op; Start = st; A = a; B = b;
        @(negedge clk);
        MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0;
    endtask

    // Counts negedges with Busy high, bounded so a stuck Busy cannot hang.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (Busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // Architectural model of HI/LO using plain integer arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        logic [63:0]     pu;
        case (op)
            4'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                pu = 64'(sa * sb);
                hi_m = pu[63:32]; lo_m = pu[31:0];
            end
            4'd2: begin
                pu = 64'(a) * 64'(b);
                hi_m = pu[63:32]; lo_m = pu[31:0];
            end
            4'd3: if (b != 32'd0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = sa / sb;
                r = sa % sb;
                lo_m = q[31:0]; hi_m = r[31:0];
            end
            4'd4: if (b != 32'd0) begin
                lo_m = a / b; hi_m = a % b;
            end
            4'd5: hi_m = a;
            4'd6: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1; MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
        n_checks++; if (MDOut !== 32'd0) begin n_fail++; $display("FAIL reset_mdout: got %h expected 00000000", MDOut); end
        $display("reset: Busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

    task automatic test_mult();
        int c;
        issue_op(4'd1, 1'b1, 32'hFFFFFFFF, 32'd2);
        wait_idle(c);
        model_op(4'd1, 32'hFFFFFFFF, 32'd2);
        n_checks++; if (c != 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 5", c); end
        n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
        n_checks++; if (LO !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffe", LO); end
        $display("mult ffffffff*2: cycles=%0d HI=%h LO=%h", c, HI, LO);
        issue_op(4'd2, 1'b1, 32'hFFFFFFFF, 32'd2);
        wait_idle(c);
        model_op(4'd2, 32'hFFFFFFFF, 32'd2);
        n_checks++; if (c != 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 5", c); end
        n_checks++; if (HI !== 32'h00000001) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000001", HI); end
        n_checks++; if (LO !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", LO); end
        $display("multu ffffffff*2: cycles=%0d HI=%h LO=%h", c, HI, LO);
    endtask

    task automatic test_div();
        int c;
        issue_op(4'd3, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_idle(c);
        model_op(4'd3, 32'hFFFFFFF9, 32'd2);
        n_checks++; if (c != 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected 10", c); end
        n_checks++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", LO); end
        n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", HI); end
        $display("div -7/2: cycles=%0d HI=%h LO=%h", c, HI, LO);
        issue_op(4'd4, 1'b1, 32'd7, 32'd2);
        wait_idle(c);
        model_op(4'd4, 32'd7, 32'd2);
        n_checks++; if (LO !== 32'd3) begin n_fail++; $display("FAIL divu_lo: got %h expected 00000003", LO); end
        n_checks++; if (HI !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000001", HI); end
        $display("divu 7/2: cycles=%0d HI=%h LO=%h", c, HI, LO);
    endtask

    task automatic test_mtx_divzero();
        int c;
        issue_op(4'd5, 1'b0, 32'h12345678, 32'd0);
        issue_op(4'd6, 1'b0, 32'h9ABCDEF0, 32'd0);
        model_op(4'd5, 32'h12345678, 32'd0);
        model_op(4'd6, 32'h9ABCDEF0, 32'd0);
        n_checks++; if (HI !== 32'h12345678) begin n_fail++; $display("FAIL mthi: got %h expected 12345678", HI); end
        n_checks++; if (LO !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo: got %h expected 9abcdef0", LO); end
        issue_op(4'd3, 1'b1, 32'd5, 32'd0);
        wait_idle(c);
        n_checks++; if (c != 10) begin n_fail++; $display("FAIL divzero_busy_cycles: got %0d expected 10", c); end
        n_checks++; if (HI !== 32'h12345678) begin n_fail++; $display("FAIL divzero_hi: got %h expected 12345678", HI); end
        n_checks++; if (LO !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL divzero_lo: got %h expected 9abcdef0", LO); end
        MDUOp = 4'd7;
        #1;
        n_checks++; if (MDOut !== 32'h12345678) begin n_fail++; $display("FAIL mfhi: got %h expected 12345678", MDOut); end
        MDUOp = 4'd8;
        #1;
        n_checks++; if (MDOut !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mflo: got %h expected 9abcdef0", MDOut); end
        MDUOp = 4'd0;
        @(negedge clk);
        $display("mthi/mtlo + div by zero: cycles=%0d HI=%h LO=%h", c, HI, LO);
    endtask

    task automatic test_busy_ignore();
        int c;
        issue_op(4'd2, 1'b1, 32'd6, 32'd7);
        model_op(4'd2, 32'd6, 32'd7);
        // Busy cycle 2: mtlo, cycle 3: a fresh mult start; both must be dropped.
        MDUOp = 4'd6; Start = 1'b0; A = 32'hDEADBEEF;
        @(negedge clk);
        MDUOp = 4'd1; Start = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(negedge clk);
        MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0;
        wait_idle(c);
        c = c + 2;
        n_checks++; if (c != 5) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d expected 5", c); end
        n_checks++; if (HI !== hi_m) begin n_fail++; $display("FAIL ignore_hi: got %h expected %h", HI, hi_m); end
        n_checks++; if (LO !== lo_m) begin n_fail++; $display("FAIL ignore_lo: got %h expected %h", LO, lo_m); end
        $display("ops during busy: cycles=%0d HI=%h LO=%h", c, HI, LO);
    endtask

    task automatic test_back_to_back();
        int c;
        issue_op(4'd1, 1'b1, 32'd3, 32'd4);
        wait_idle(c);
        n_checks++; if (LO !== 32'd12) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 0000000c", LO); end
        // Busy has just fallen: start the next op on the very next edge.
        issue_op(4'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(c);
        model_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        n_checks++; if (c != 10) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 10", c); end
        n_checks++; if (LO !== 32'h80000000) begin n_fail++; $display("FAIL b2b_ovf_lo: got %h expected 80000000", LO); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL b2b_ovf_hi: got %h expected 00000000", HI); end
        $display("back-to-back div 80000000/ffffffff: cycles=%0d HI=%h LO=%h", c, HI, LO);
    endtask

    task automatic test_random();
        int          c, exp_n;
        logic [3:0]  op;
        logic        st;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 5) == 0) a = -a;
            st = (op <= 4'd4) ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
            exp_n = 0;
            if (op <= 4'd4) begin
                if (st) begin
                    model_op(op, a, b);
                    exp_n = (op <= 4'd2) ? 5 : 10;
                end
            end else begin
                model_op(op, a, b);
            end
            issue_op(op, st, a, b);
            wait_idle(c);
            n_checks++; if (c != exp_n) begin n_fail++; $display("FAIL rand%0d_cycles: got %0d expected %0d", i, c, exp_n); end
            n_checks++; if (HI !== hi_m) begin n_fail++; $display("FAIL rand%0d_hi: got %h expected %h", i, HI, hi_m); end
            n_checks++; if (LO !== lo_m) begin n_fail++; $display("FAIL rand%0d_lo: got %h expected %h", i, LO, lo_m); end
            MDUOp = 4'd7;
            #1;
            n_checks++; if (MDOut !== hi_m) begin n_fail++; $display("FAIL rand%0d_mfhi: got %h expected %h", i, MDOut, hi_m); end
            MDUOp = 4'd8;
            #1;
            n_checks++; if (MDOut !== lo_m) begin n_fail++; $display("FAIL rand%0d_mflo: got %h expected %h", i, MDOut, lo_m); end
            MDUOp = 4'd0;
            #1;
            n_checks++; if (MDOut !== 32'd0) begin n_fail++; $display("FAIL rand%0d_mdout_none: got %h expected 00000000", i, MDOut); end
            @(negedge clk);
            $display("rand %0d: op=%0d start=%b A=%h B=%h cycles=%0d HI=%h LO=%h", i, op, st, a, b, c, HI, LO);
        end
    endtask

    task automatic test_reset_mid_div();
        issue_op(4'd5, 1'b0, 32'h11, 32'd0);
        issue_op(4'd6, 1'b0, 32'h22, 32'd0);
        issue_op(4'd3, 1'b1, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", Busy); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL midreset_hi: got %h expected 00000000", HI); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL midreset_lo: got %h expected 00000000", LO); end
        reset = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_late_busy: got %b expected 0", Busy); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL midreset_late_hi: got %h expected 00000000", HI); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL midreset_late_lo: got %h expected 00000000", LO); end
        $display("reset mid-div: Busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtx_divzero();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Consumes the two source operands read from the register file in D (after forwarding), carried into E by the D/E pipeline register. Models the MIPS HI/LO pair with fixed-latency mult/div. Exposes Busy so the hazard logic can stall MD-class instructions in D.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
Start  input  1  qualifies MDUOp 1-4 as a new operation this cycle
A  input  32  operand rs (forwarded)
B  input  32  operand rt (forwarded)
Busy  output  1  operation in progress
HI  output  32  current HI register
LO  output  32  current LO register
MDOut  output  32  mfhi→HI, mflo→LO, otherwise 0 (combinational)

Behaviour:
- Reset (clk edge with reset=1): HI=0, LO=0, Busy=0, counter=0, pending results=0. Reset dominates; it aborts an in-flight op and discards its pending result.
- State: IDLE / RUN. Busy is registered and equals (state==RUN).
- IDLE, Start=1, MDUOp∈{1..4}: at that edge, compute the full result from A/B into pending regs {pHI,pLO}. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN. HI/LO are unchanged.
- RUN: counter decrements each edge. On the edge where counter reaches 0: HI←pHI, LO←pLO, Busy→0, and go to IDLE.
- Timing: Start sampled at edge T. Busy is high for exactly N cycles (edges T+1..T+N). HI/LO show the new values and Busy=0 after edge T+N.
- In RUN, Start and all MDUOp values are ignored, including mthi/mtlo. Upstream stalls any MD-class instruction while Start|Busy.
- mthi (5) / mtlo (6) in IDLE: HI←A or LO←A at the edge. Start is not required.
- mfhi/mflo: MDOut is combinational from the current HI/LO. No stall is implied in IDLE.
- Start with MDUOp∉{1..4}: no operation starts. Ops 5/6 still act.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}=product.
  - multu: unsigned 32×32→64.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (A).
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, div or divu): runs the full DIV_CYCLES with Busy high. HI/LO are left unchanged at completion.
- Back-to-back: a new Start is accepted in the same cycle Busy has just fallen, i.e. edge T+N+1 at the earliest.
- Internal counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Test Plan:
- Reset, then idle → HI=0, LO=0, Busy=0, MDOut=0. Assert reset mid-div (cycle 4 of 10) → next edge Busy=0, HI/LO=0, and no later write.
- mult A=0xFFFFFFFF, B=2, Start at T → Busy 1 for edges T+1..T+5; after T+5 HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu A=7, B=2 → LO=3, HI=1.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 with div B=0 → HI/LO keep 0x12345678/0x9ABCDEF0 after 10 Busy cycles. mfhi → MDOut=0x12345678.
- During Busy, drive mtlo A=0xDEADBEEF and Start with mult → both ignored; final HI/LO are those of the original op, and Busy lasts exactly N cycles.
- Start mult, then Start div on the first cycle Busy=0 → accepted, Busy for 10 more cycles. Div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
